histogram_reader: RTL and testbench

Readout engine for the histogram bin memory that histogram_unit fills. On START it scans bins 0..MAX_NUMBER through a synchronous-read memory port and streams each (bin, count) pair out over a valid/ready interface. It can optionally clear each bin after it has been read, and it reports the total of all counts read. It sits between the histogram RAM and the downstream consumer (UART/display formatter).

---
 rtl/histogram_reader_pkg.sv | 23 ++
 rtl/histogram_reader_if.sv | 29 ++
 rtl/histogram_reader.sv | 107 ++++++++++
 tb/tb_histogram_reader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/histogram_reader_pkg.sv
// Shared types and width helpers for the histogram unit and its readout engine.
// Both blocks size the bin address and count totals from the same functions.
package histogram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WT,
        OUT,
        CLR,
        FIN
    } state_t;

    function automatic int addr_width(input int max_number);
        return (max_number < 1) ? 1 : $clog2(max_number + 1);
    endfunction

    // A full scan sums at most (max_number+1) counts of size bits each.
    function automatic int total_width(input int size, input int max_number);
        return size + addr_width(max_number);
    endfunction

endpackage

// File: rtl/histogram_reader_if.sv
// Bin-memory port and (bin, count) beat stream of the histogram readout engine.
interface histogram_reader_if #(
    parameter int AW   = 7,
    parameter int SIZE = 7
);
    logic [AW-1:0]   mem_addr;
    logic            mem_rd;
    logic [SIZE-1:0] mem_data;
    logic            mem_wr;
    logic [SIZE-1:0] mem_wdata;

    logic [AW-1:0]   dout_bin;
    logic [SIZE-1:0] dout_count;
    logic            dout_valid;
    logic            dout_ready;
    logic            dout_last;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        output dout_bin, dout_count, dout_valid, dout_last,
        input  mem_data, dout_ready
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        input  dout_bin, dout_count, dout_valid, dout_last,
        output mem_data, dout_ready
    );
endinterface

// File: rtl/histogram_reader.sv
// Scans histogram bins 0..MAX_NUMBER, streams each (bin, count) beat and sums the counts.
// Optionally zeroes each bin once its beat has been accepted downstream.
//
// state | meaning
// IDLE  | waiting for START
// RD    | read strobe for the current bin
// WT    | memory returns data; capture beat and accumulate total
// OUT   | beat presented, waiting for dout_ready
// CLR   | write 0 back to the current bin
// FIN   | one-cycle DONE, then back to IDLE
module histogram_reader
    import histogram_pkg::*;
#(
    parameter int  SIZE          = 7,
    parameter int  MAX_NUMBER    = 127,
    parameter bit  CLEAR_ON_READ = 1'b1,
    localparam int AW            = addr_width(MAX_NUMBER),
    localparam int TW            = total_width(SIZE, MAX_NUMBER)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [TW-1:0]         total,
    histogram_reader_if.master    bus
);

    state_t          state, state_nxt;
    logic [AW-1:0]   addr;
    logic [AW-1:0]   bin_q;
    logic [SIZE-1:0] count_q;
    logic [TW-1:0]   total_q;
    logic            at_max;
    logic            advance;

    assign at_max = (addr == AW'(MAX_NUMBER));

    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        unique case (state)
            IDLE: if (START) state_nxt = RD;
            RD:   state_nxt = WT;
            WT:   state_nxt = OUT;
            OUT: begin
                if (bus.dout_ready) begin
                    if (CLEAR_ON_READ) begin
                        state_nxt = CLR;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = at_max ? FIN : RD;
                    end
                end
            end
            CLR: begin
                advance   = 1'b1;
                state_nxt = at_max ? FIN : RD;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= IDLE;
            addr    <= '0;
            bin_q   <= '0;
            count_q <= '0;
            total_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (START) begin
                        addr    <= '0;
                        total_q <= '0;
                    end
                end
                WT: begin
                    count_q <= bus.mem_data;
                    bin_q   <= addr;
                    total_q <= total_q + TW'(bus.mem_data);
                end
                default: ;
            endcase
            // Address stops at MAX_NUMBER; the scan ends there instead of wrapping.
            if (advance && !at_max)
                addr <= addr + AW'(1);
        end
    end

    assign BUSY           = (state != IDLE);
    assign DONE           = (state == FIN);
    assign total          = total_q;

    assign bus.mem_addr   = addr;
    assign bus.mem_rd     = (state == RD);
    assign bus.mem_wr     = (state == CLR);
    assign bus.mem_wdata  = '0;
    assign bus.dout_bin   = bin_q;
    assign bus.dout_count = count_q;
    assign bus.dout_valid = (state == OUT);
    assign bus.dout_last  = (state == OUT) && at_max;

endmodule

// File: tb/tb_histogram_reader.sv
// Directed bench for histogram_reader: one clear-on-read and one read-only instance,
// each backed by a 1-cycle-latency synchronous RAM model.
module tb_histogram_reader;

    typedef struct {
        int sel;        // 0: clear-on-read DUT, 1: read-only DUT
        int pat;        // preload pattern
        int rmode;      // 0: ready tied high, 1: ready toggles
        int poke;       // bin at which a stray START is pulsed, -1 for none
        int exp_total;
        int exp_done;   // expected START->DONE cycles, 0 = not checked
        int ram_mode;   // 0: no RAM check, 1: all zero, 2: unchanged identity
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;
    logic busy_a, busy_b, done_a, done_b;
    logic [13:0] total_a, total_b;
    logic [6:0] ram_a [128];
    logic [6:0] ram_b [128];
    logic load_req = 1'b0;
    int   load_pat = 0;
    int   edge_cnt = 0;
    int   errors = 0;
    int   checks = 0;
    int   sel = 0;

    logic       m_valid, m_last, m_rd, m_wr, m_done, m_busy;
    logic [6:0] m_bin, m_count, m_addr;
    logic [13:0] m_total;

    histogram_reader_if #(.AW(7), .SIZE(7)) bus_a ();
    histogram_reader_if #(.AW(7), .SIZE(7)) bus_b ();

    histogram_reader #(.SIZE(7), .MAX_NUMBER(127), .CLEAR_ON_READ(1'b1)) dut_a (
        .CLK(clk), .RST(rst), .START(start_a), .BUSY(busy_a), .DONE(done_a),
        .total(total_a), .bus(bus_a.master)
    );

    histogram_reader #(.SIZE(7), .MAX_NUMBER(127), .CLEAR_ON_READ(1'b0)) dut_b (
        .CLK(clk), .RST(rst), .START(start_b), .BUSY(busy_b), .DONE(done_b),
        .total(total_b), .bus(bus_b.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [6:0] pat_val(input int pat, input int i);
        case (pat)
            0:       return 7'(i);
            1:       return 7'd127;
            default: return (i < 40) ? 7'd0 : 7'(i);
        endcase
    endfunction

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 128; i++) begin
                ram_a[i] <= pat_val(load_pat, i);
                ram_b[i] <= pat_val(load_pat, i);
            end
        end else begin
            if (bus_a.mem_wr) ram_a[bus_a.mem_addr] <= bus_a.mem_wdata;
            if (bus_b.mem_wr) ram_b[bus_b.mem_addr] <= bus_b.mem_wdata;
        end
        if (bus_a.mem_rd) bus_a.mem_data <= ram_a[bus_a.mem_addr];
        if (bus_b.mem_rd) bus_b.mem_data <= ram_b[bus_b.mem_addr];
    end

    always_comb begin
        m_valid = (sel == 0) ? bus_a.dout_valid : bus_b.dout_valid;
        m_last  = (sel == 0) ? bus_a.dout_last  : bus_b.dout_last;
        m_bin   = (sel == 0) ? bus_a.dout_bin   : bus_b.dout_bin;
        m_count = (sel == 0) ? bus_a.dout_count : bus_b.dout_count;
        m_addr  = (sel == 0) ? bus_a.mem_addr   : bus_b.mem_addr;
        m_rd    = (sel == 0) ? bus_a.mem_rd     : bus_b.mem_rd;
        m_wr    = (sel == 0) ? bus_a.mem_wr     : bus_b.mem_wr;
        m_done  = (sel == 0) ? done_a  : done_b;
        m_busy  = (sel == 0) ? busy_a  : busy_b;
        m_total = (sel == 0) ? total_a : total_b;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 0) start_a = v; else start_b = v;
    endtask

    task automatic set_ready(input int s, input logic v);
        if (s == 0) bus_a.dout_ready = v; else bus_b.dout_ready = v;
    endtask

    task automatic load(input int pat);
        @(posedge clk); #1;
        load_pat = pat;
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic check_ram(input int mode, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            if (mode == 1 && ram_a[i] !== 7'd0) bad++;
            if (mode == 2 && ram_b[i] !== 7'(i)) bad++;
            if (mode == 3 && ram_a[i] !== pat_val(2, i)) bad++;
        end
        chk({tag, " ram_bad_bins"}, bad, 0);
    endtask

    task automatic do_scan(input int s, input int pat, input int rmode, input int poke,
                           input int exp_total, input int exp_done, input string tag);
        int idx, n0, first_v, done_at, both;
        logic stall, rdy, poke_now;
        logic [6:0] hb, hc;
        idx = 0; first_v = -1; done_at = -1; both = 0;
        stall = 1'b0; rdy = 1'b1; poke_now = 1'b0; hb = '0; hc = '0;
        sel = s;
        @(posedge clk); #1;
        set_ready(s, 1'b1);
        set_start(s, 1'b1);
        n0 = edge_cnt;
        @(posedge clk); #1;
        set_start(s, 1'b0);
        for (int c = 0; c < 2000 && done_at < 0; c++) begin
            @(negedge clk);
            if (m_rd && m_wr) both++;
            if (m_valid) begin
                if (first_v < 0) first_v = edge_cnt - n0;
                if (stall) begin
                    chk({tag, " stall_bin"}, m_bin, hb);
                    chk({tag, " stall_count"}, m_count, hc);
                end
                if (rdy) begin
                    chk({tag, " beat_bin"}, m_bin, idx);
                    chk({tag, " beat_count"}, m_count, pat_val(pat, idx));
                    chk({tag, " beat_last"}, m_last, (idx == 127));
                    if (idx == poke) poke_now = 1'b1;
                    idx++;
                end
                stall = !rdy;
                hb = m_bin;
                hc = m_count;
            end else begin
                stall = 1'b0;
            end
            if (m_done) done_at = edge_cnt - n0;
            @(posedge clk); #1;
            set_start(s, poke_now);
            poke_now = 1'b0;
            if (rmode == 1) rdy = !rdy;
            set_ready(s, rdy);
        end
        set_start(s, 1'b0);
        chk({tag, " done_seen"}, (done_at >= 0), 1);
        chk({tag, " beats"}, idx, 128);
        if (exp_done > 0) chk({tag, " done_latency"}, done_at, exp_done);
        if (rmode == 0) chk({tag, " first_valid_latency"}, first_v, 3);
        chk({tag, " total"}, m_total, exp_total);
        chk({tag, " rd_wr_overlap"}, both, 0);
        @(negedge clk);
        chk({tag, " busy_after_done"}, m_busy, 0);
        chk({tag, " total_hold"}, m_total, exp_total);
    endtask

    vec_t vecs [6];

    initial begin
        int found;
        vecs[0] = '{sel: 0, pat: 0, rmode: 0, poke: -1, exp_total: 8128,  exp_done: 513, ram_mode: 1};
        vecs[1] = '{sel: 0, pat: 0, rmode: 1, poke: -1, exp_total: 8128,  exp_done: 0,   ram_mode: 1};
        vecs[2] = '{sel: 1, pat: 0, rmode: 0, poke: -1, exp_total: 8128,  exp_done: 385, ram_mode: 2};
        vecs[3] = '{sel: 1, pat: 0, rmode: 0, poke: -1, exp_total: 8128,  exp_done: 385, ram_mode: 2};
        vecs[4] = '{sel: 0, pat: 1, rmode: 0, poke: -1, exp_total: 16256, exp_done: 513, ram_mode: 1};
        vecs[5] = '{sel: 0, pat: 0, rmode: 0, poke: 20, exp_total: 8128,  exp_done: 513, ram_mode: 1};

        bus_a.dout_ready = 1'b1;
        bus_b.dout_ready = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", busy_a, 0);
        chk("reset valid", bus_a.dout_valid, 0);
        chk("reset done", done_a, 0);
        chk("reset total", total_a, 0);
        chk("reset mem_rd", bus_a.mem_rd, 0);
        #1 rst = 1'b1;

        for (int v = 0; v < 6; v++) begin
            // Read-only vectors 2 and 3 run back to back on the same RAM contents.
            if (v != 3) load(vecs[v].pat);
            do_scan(vecs[v].sel, vecs[v].pat, vecs[v].rmode, vecs[v].poke,
                    vecs[v].exp_total, vecs[v].exp_done, $sformatf("vec%0d", v));
            if (vecs[v].ram_mode != 0) check_ram(vecs[v].ram_mode, $sformatf("vec%0d", v));
        end

        // Reset while bin 40 is presented: bins below 40 are already cleared.
        load(0);
        sel = 0;
        @(posedge clk); #1;
        bus_a.dout_ready = 1'b1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        found = 0;
        for (int c = 0; c < 1000 && found == 0; c++) begin
            @(negedge clk);
            if (bus_a.dout_valid && bus_a.dout_bin == 7'd40) found = 1;
        end
        chk("rst reached_bin40", found, 1);
        rst = 1'b0;
        bus_a.dout_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        bus_a.dout_ready = 1'b1;
        @(negedge clk);
        chk("rst busy", busy_a, 0);
        chk("rst valid", bus_a.dout_valid, 0);
        chk("rst last", bus_a.dout_last, 0);
        chk("rst done", done_a, 0);
        chk("rst mem_rd", bus_a.mem_rd, 0);
        chk("rst mem_wr", bus_a.mem_wr, 0);
        chk("rst mem_addr", bus_a.mem_addr, 0);
        chk("rst dout_bin", bus_a.dout_bin, 0);
        chk("rst dout_count", bus_a.dout_count, 0);
        chk("rst total", total_a, 0);
        check_ram(3, "rst");
        do_scan(0, 2, 0, -1, 7348, 513, "restart");
        check_ram(1, "restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
